unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-port, variable-latency unified memory between the fetch stage (instruction reads at PCF) and the memory stage (data loads/stores at ALUResultM). It grants one transaction at a time, registers the memory request, and returns the read data. It pulses per-requester ready strobes, which the hazard control unit turns into StallF/StallM. Data has priority, with an anti-starvation guard for fetch, a fetch-kill for redirects, and a bus-timeout error.

Parameters:
MAX_DATA_GRANTS, 4, consecutive data grants allowed while a fetch is pending before fetch is forced.
TIMEOUT_CYCLES, 256, MemReq cycles without MemAck before the transaction is aborted.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
FetchReqF  in  1  fetch read request, held until FetchReadyF
PCF  in  32  fetch address
FetchKillF  in  1  redirect; discard the pending or in-flight fetch
InstrF  out  32  fetched instruction, valid with FetchReadyF
FetchReadyF  out  1  one-cycle fetch completion strobe
DataReqM  in  1  data request, held until DataReadyM
MemWriteM  in  1  1=store, 0=load
ALUResultM  in  32  data address
WriteDataM  in  32  store data
ByteEnM  in  4  store byte enables
ReadDataM  out  32  load data, valid with DataReadyM
DataReadyM  out  1  one-cycle data completion strobe
MemReq  out  1  memory request valid
MemAddr  out  32  memory address
MemWData  out  32  memory write data
MemBE  out  4  memory byte enables (4'hF on reads)
MemWE  out  1  memory write enable
MemAck  in  1  memory accepts/completes; MemRData valid same cycle
MemRData  in  32  memory read data
BusErr  out  1  sticky timeout flag

Behaviour:
- Reset (sync): state IDLE; all outputs 0; grant counter, timeout counter and kill flag cleared. Reset mid-transaction drops the transaction with no ready strobe.
- States: IDLE, FETCH_BUSY, DATA_BUSY.
- IDLE arbitration:
  - A request is ignored in any cycle where its own ready strobe is high.
  - Data wins, unless a fetch is pending and grant_cnt==MAX_DATA_GRANTS; then fetch wins.
  - A fetch with FetchKillF high in the same cycle is not granted.
- On grant:
  - MemAddr, MemWData, MemBE and MemWE are registered from the granted requester.
  - MemReq goes to 1 on the next cycle.
  - Fetch grants set MemWE=0 and MemBE=4'hF.
- grant_cnt: +1 per data grant while FetchReqF is high; saturates at MAX_DATA_GRANTS; cleared on any fetch grant or when FetchReqF is low.
- BUSY: MemReq and the address/data registers are held stable until MemAck.
  - On the MemAck edge: MemReq←0, state←IDLE, and the matching ready←1 for exactly one cycle.
  - Data read: ReadDataM←MemRData. Fetch: InstrF←MemRData.
  - Stores leave ReadDataM unchanged.
- Latency: request sampled in IDLE at cycle N → MemReq high at N+1 → MemAck at cycle N+k (k≥1) → ready high at N+k+1. Zero-wait memory gives 2 cycles request-to-ready.
- InstrF and ReadDataM hold their last value between strobes.
- FetchKillF in FETCH_BUSY (including the MemAck cycle) sets kill. On ack: no FetchReadyF, InstrF unchanged, kill cleared, return to IDLE. FetchKillF has no effect in DATA_BUSY.
- Timeout: the counter increments each BUSY cycle without MemAck. When it reaches TIMEOUT_CYCLES:
  - MemReq←0, state←IDLE, BusErr←1 (sticky until reset).
  - Complete with a ready strobe and data 0, unless the fetch was killed.
- MemAck while MemReq==0 is ignored.
- Counter width is clog2(TIMEOUT_CYCLES+1). No wrap: the counter is cleared on every grant.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, FETCH_BUSY=2'd1, DATA_BUSY=2'd2), the 4'hF read byte-enable constant, and the clog2-based width function.
- One natural sub-module: arb_timeout_counter (clear/enable/expire, parameterised by TIMEOUT_CYCLES).
- FSM, registers and starvation counter stay in the top module.

Test Plan:
- Fetch only: PCF=0x100, zero-wait memory, MemRData=0x00500093 → MemReq at N+1 with MemAddr=0x100, MemBE=4'hF, MemWE=0; FetchReadyF at N+2 with InstrF=0x00500093.
- Simultaneous requests: FetchReqF, and store DataReqM with addr 0x2000, WriteDataM=0xDEADBEEF, ByteEnM=4'b0011 → data granted first (MemWE=1, MemBE=4'b0011); DataReadyM pulses; fetch granted on the next IDLE cycle.
- Starvation: DataReqM re-asserted continuously with fetch pending, MAX_DATA_GRANTS=4 → exactly 4 data grants, then a fetch grant, then data resumes.
- Kill: fetch in flight with 3 wait states; FetchKillF pulsed on wait cycle 2 → no FetchReadyF, InstrF unchanged; a new fetch at 0x200 issues normally afterwards.
- Timeout: TIMEOUT_CYCLES=8, MemAck held 0 on a load → MemReq drops after 8 cycles; DataReadyM pulses with ReadDataM=0; BusErr=1 until reset.
- Reset in DATA_BUSY, then MemAck → no ready strobe; all outputs 0; state IDLE.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and helpers for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StFetchBusy = 2'd1,
    StDataBusy  = 2'd2
  } arb_state_e;

  localparam logic [3:0] ReadByteEn = 4'hF;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_arb_timeout_counter.sv
// Counts busy cycles without an acknowledge; flags the cycle in which the limit is reached.
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  import unified_mem_arbiter_pkg::*;

  localparam int unsigned Width = cnt_width(TIMEOUT_CYCLES);
  localparam logic [Width-1:0] Limit = Width'(TIMEOUT_CYCLES);
  localparam logic [Width-1:0] Last  = Width'(TIMEOUT_CYCLES - 1);

  logic [Width-1:0] count;

  assign expire = enable && (count == Last);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != Limit)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between fetch and data requesters.
module unified_mem_arbiter #(
  parameter int unsigned MAX_DATA_GRANTS = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FetchReqF,
  input  logic [31:0] PCF,
  input  logic        FetchKillF,
  output logic [31:0] InstrF,
  output logic        FetchReadyF,
  input  logic        DataReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic [31:0] ReadDataM,
  output logic        DataReadyM,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBE,
  output logic        MemWE,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        BusErr
);
  import unified_mem_arbiter_pkg::*;

  localparam int unsigned GrantWidth = cnt_width(MAX_DATA_GRANTS);
  localparam logic [GrantWidth-1:0] MaxGrants = GrantWidth'(MAX_DATA_GRANTS);

  arb_state_e            state;
  logic [GrantWidth-1:0] grant_cnt;
  logic                  kill;

  logic fetch_pend, data_pend, force_fetch;
  logic grant_fetch, grant_data;
  logic ack, to_enable, to_expire;

  always_comb begin
    // A requester is not re-granted in the cycle its completion strobe is visible.
    fetch_pend  = FetchReqF && !FetchReadyF && !FetchKillF;
    data_pend   = DataReqM && !DataReadyM;
    force_fetch = fetch_pend && (grant_cnt == MaxGrants);
    grant_data  = (state == StIdle) && data_pend && !force_fetch;
    grant_fetch = (state == StIdle) && fetch_pend && !grant_data;
    ack         = MemAck && MemReq;
    to_enable   = (state != StIdle) && MemReq && !MemAck;
  end

  arb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (grant_data || grant_fetch),
    .enable(to_enable),
    .expire(to_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      grant_cnt   <= '0;
      kill        <= 1'b0;
      MemReq      <= 1'b0;
      MemAddr     <= '0;
      MemWData    <= '0;
      MemBE       <= '0;
      MemWE       <= 1'b0;
      InstrF      <= '0;
      FetchReadyF <= 1'b0;
      ReadDataM   <= '0;
      DataReadyM  <= 1'b0;
      BusErr      <= 1'b0;
    end else begin
      FetchReadyF <= 1'b0;
      DataReadyM  <= 1'b0;

      if (!FetchReqF || grant_fetch) begin
        grant_cnt <= '0;
      end else if (grant_data && (grant_cnt != MaxGrants)) begin
        grant_cnt <= grant_cnt + 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (grant_data) begin
            state    <= StDataBusy;
            MemReq   <= 1'b1;
            MemAddr  <= ALUResultM;
            MemWData <= WriteDataM;
            MemBE    <= MemWriteM ? ByteEnM : ReadByteEn;
            MemWE    <= MemWriteM;
          end else if (grant_fetch) begin
            state    <= StFetchBusy;
            MemReq   <= 1'b1;
            MemAddr  <= PCF;
            MemWData <= '0;
            MemBE    <= ReadByteEn;
            MemWE    <= 1'b0;
          end
        end
        StFetchBusy: begin
          if (ack || to_expire) begin
            state  <= StIdle;
            MemReq <= 1'b0;
            kill   <= 1'b0;
            if (to_expire) BusErr <= 1'b1;
            // A kill seen earlier or in this very cycle swallows the result.
            if (!kill && !FetchKillF) begin
              FetchReadyF <= 1'b1;
              InstrF      <= ack ? MemRData : '0;
            end
          end else if (FetchKillF) begin
            kill <= 1'b1;
          end
        end
        StDataBusy: begin
          if (ack || to_expire) begin
            state      <= StIdle;
            MemReq     <= 1'b0;
            DataReadyM <= 1'b1;
            if (to_expire) BusErr <= 1'b1;
            if (!MemWE) ReadDataM <= ack ? MemRData : '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a memory reference model.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        FetchReqF, FetchKillF, FetchReadyF;
  logic [31:0] PCF, InstrF;
  logic        DataReqM, MemWriteM, DataReadyM;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic [3:0]  ByteEnM;
  logic        MemReq, MemWE, MemAck, BusErr;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic [3:0]  MemBE;

  int n_checks = 0;
  int n_errors = 0;

  unified_mem_arbiter #(
    .MAX_DATA_GRANTS(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .FetchReqF  (FetchReqF),
    .PCF        (PCF),
    .FetchKillF (FetchKillF),
    .InstrF     (InstrF),
    .FetchReadyF(FetchReadyF),
    .DataReqM   (DataReqM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ByteEnM    (ByteEnM),
    .ReadDataM  (ReadDataM),
    .DataReadyM (DataReadyM),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemBE      (MemBE),
    .MemWE      (MemWE),
    .MemAck     (MemAck),
    .MemRData   (MemRData),
    .BusErr     (BusErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents: unwritten words read back as an address-derived pattern.
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : mem_default(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  // Memory responder: decides MemAck for the coming edge, 2 time units after each edge.
  int mem_wait = 0;
  bit mem_hang = 0, mem_force_ack = 0, mem_rand = 0;
  int seen = 0, cur_wait = 0;

  initial begin
    MemAck   = 1'b0;
    MemRData = '0;
  end

  always begin
    @(posedge clk);
    #2;
    if (mem_force_ack) begin
      MemAck   = 1'b1;
      MemRData = 32'hBAD0_BAD0;
    end else if (MemReq) begin
      if (seen == 0) cur_wait = mem_rand ? int'($urandom_range(0, 4)) : mem_wait;
      if (!mem_hang && seen >= cur_wait) begin
        MemAck = 1'b1;
        if (MemWE) begin
          MemRData     = $urandom;
          mem[MemAddr] = merge(mem_rd(MemAddr), MemWData, MemBE);
        end else begin
          MemRData = mem_rd(MemAddr);
        end
        seen = 0;
      end else begin
        MemAck = 1'b0;
        seen++;
      end
    end else begin
      MemAck = 1'b0;
      seen   = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] exp_instr, last_ga, last_load, f_addr, d_addr, d_wd;
    logic [3:0]  d_be;
    logic [5:0]  seq_mask;
    bit          prev, got, f_act, d_act, d_st;
    int          ngr, held_bad, hi;

    reset = 1'b1;
    FetchReqF = 0; PCF = '0; FetchKillF = 0;
    DataReqM = 0; MemWriteM = 0; ALUResultM = '0; WriteDataM = '0; ByteEnM = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_memreq", MemReq, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_instr", InstrF, 0);
    check("rst_rdata", ReadDataM, 0);
    check("rst_strobes", {FetchReadyF, DataReadyM, BusErr, MemWE}, 0);

    // Fetch only, zero-wait memory.
    mem[32'h100] = 32'h0050_0093;
    FetchReqF = 1; PCF = 32'h100;
    tick();
    check("f1_memreq", MemReq, 1);
    check("f1_addr", MemAddr, 32'h100);
    check("f1_be_we", {MemBE, MemWE}, {4'hF, 1'b0});
    check("f1_noready", FetchReadyF, 0);
    tick();
    check("f1_ready", FetchReadyF, 1);
    check("f1_instr", InstrF, 32'h0050_0093);
    FetchReqF = 0;
    tick();
    check("f1_pulse", FetchReadyF, 0);
    check("f1_hold", InstrF, 32'h0050_0093);

    // Simultaneous store and fetch: data first, fetch in the next idle cycle.
    mem[32'h2000] = 32'h1122_3344;
    mem[32'h104]  = 32'h00A0_0113;
    FetchReqF = 1; PCF = 32'h104;
    DataReqM = 1; MemWriteM = 1; ALUResultM = 32'h2000;
    WriteDataM = 32'hDEAD_BEEF; ByteEnM = 4'b0011;
    tick();
    check("sim_addr", MemAddr, 32'h2000);
    check("sim_we_be", {MemWE, MemBE}, {1'b1, 4'b0011});
    check("sim_wdata", MemWData, 32'hDEAD_BEEF);
    tick();
    check("sim_dready", DataReadyM, 1);
    check("sim_no_fready", FetchReadyF, 0);
    DataReqM = 0; MemWriteM = 0;
    tick();
    check("sim_fgrant", {MemReq, MemWE}, {1'b1, 1'b0});
    check("sim_faddr", MemAddr, 32'h104);
    tick();
    check("sim_fready", FetchReadyF, 1);
    check("sim_instr", InstrF, 32'h00A0_0113);
    check("sim_merge", mem_rd(32'h2000), 32'h1122_BEEF);
    FetchReqF = 0;
    tick();

    // Starvation guard. Fetch is masked by FetchKillF in each data-ready cycle so data keeps
    // winning the idle slots until the grant counter forces the fetch through.
    FetchReqF = 1; PCF = 32'h300;
    DataReqM = 1; MemWriteM = 0; ALUResultM = 32'h2100; ByteEnM = 4'h0;
    ngr = 0; seq_mask = '0; prev = MemReq;
    for (int c = 0; c < 100 && ngr < 6; c++) begin
      tick();
      if (MemReq && !prev) begin
        if (!MemWE && MemAddr == 32'h300) seq_mask[ngr] = 1'b1;
        ngr++;
      end
      prev = MemReq;
      if (FetchReadyF) FetchReqF = 0;
      FetchKillF = DataReadyM && FetchReqF;
    end
    check("starve_grants", ngr, 6);
    check("starve_seq", {26'b0, seq_mask}, 32'h10);
    DataReqM = 0; FetchKillF = 0; FetchReqF = 0;
    repeat (6) tick();
    check("starve_rdata", ReadDataM, mem_rd(32'h2100));

    // Kill an in-flight fetch with three wait states, then redirect to 0x200.
    exp_instr = mem_rd(32'h300);
    mem_wait = 3;
    FetchReqF = 1; PCF = 32'h180;
    tick();
    tick();
    FetchKillF = 1;
    tick();
    FetchKillF = 0; PCF = 32'h200; mem_wait = 0;
    got = 0; held_bad = 0; last_ga = '0; prev = MemReq;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (MemReq && !prev) last_ga = MemAddr;
      prev = MemReq;
      if (FetchReadyF) got = 1;
      else if (InstrF !== exp_instr) held_bad++;
    end
    check("kill_ready_seen", got, 1);
    check("kill_held", held_bad, 0);
    check("kill_regrant", last_ga, 32'h200);
    check("kill_instr", InstrF, mem_rd(32'h200));
    FetchReqF = 0;
    tick();

    // Load that never gets an acknowledge.
    mem_hang = 1;
    DataReqM = 1; MemWriteM = 0; ALUResultM = 32'h2040;
    tick();
    hi = 0;
    while (MemReq && hi < 20) begin
      hi++;
      tick();
    end
    check("to_cycles", hi, 8);
    check("to_dready", DataReadyM, 1);
    check("to_rdata", ReadDataM, 0);
    check("to_buserr", BusErr, 1);
    DataReqM = 0; mem_hang = 0;
    tick();
    tick();
    check("to_sticky", BusErr, 1);
    check("to_pulse", DataReadyM, 0);

    // Reset while a load is outstanding, with an acknowledge arriving at the same edge.
    mem_hang = 1;
    DataReqM = 1; ALUResultM = 32'h2080;
    tick();
    tick();
    check("rb_busy", MemReq, 1);
    reset = 1; DataReqM = 0; mem_force_ack = 1;
    tick();
    check("rb_memreq", MemReq, 0);
    check("rb_outs", {MemAddr | MemWData | InstrF | ReadDataM}, 0);
    check("rb_flags", {FetchReadyF, DataReadyM, BusErr, MemWE, MemBE}, 0);
    reset = 0;
    tick();
    check("rb_noack", {MemReq, DataReadyM, FetchReadyF}, 0);
    mem_force_ack = 0; mem_hang = 0;
    tick();

    // Randomized traffic: fetch from 0x1xxx, loads/stores to 0x3xxx, random wait states.
    mem_rand = 1;
    f_act = 0; d_act = 0; d_st = 0;
    f_addr = '0; d_addr = '0; d_wd = '0; d_be = '0;
    last_load = ReadDataM === 32'h0 ? 32'h0 : 32'hFFFF_FFFF;
    last_load = 32'h0;
    prev = MemReq;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (MemReq && !prev) begin
        if (MemAddr[15:12] == 4'h1) begin
          check("rnd_faddr", MemAddr, f_addr);
          check("rnd_fctl", {MemWE, MemBE}, {1'b0, 4'hF});
        end else begin
          check("rnd_daddr", MemAddr, d_addr);
          check("rnd_dwe", MemWE, d_st);
          check("rnd_dbe", MemBE, d_st ? d_be : 4'hF);
          if (d_st) check("rnd_dwdata", MemWData, d_wd);
        end
      end
      prev = MemReq;
      if (FetchReadyF) begin
        check("rnd_fspur", f_act, 1);
        check("rnd_instr", InstrF, ref_rd(f_addr));
        f_act = 0; FetchReqF = 0;
      end
      if (DataReadyM) begin
        check("rnd_dspur", d_act, 1);
        if (d_st) begin
          ref_mem[d_addr] = merge(ref_rd(d_addr), d_wd, d_be);
          check("rnd_st_hold", ReadDataM, last_load);
        end else begin
          check("rnd_load", ReadDataM, ref_rd(d_addr));
          last_load = ref_rd(d_addr);
        end
        d_act = 0; DataReqM = 0;
      end
      if (c < 360 && !f_act && !FetchReadyF && $urandom_range(0, 2) == 0) begin
        f_act = 1;
        f_addr = 32'h1000 + ($urandom_range(0, 15) << 2);
        FetchReqF = 1; PCF = f_addr;
      end
      if (c < 360 && !d_act && !DataReadyM && $urandom_range(0, 2) == 0) begin
        d_act = 1;
        d_addr = 32'h3000 + ($urandom_range(0, 15) << 2);
        d_st = 1'($urandom_range(0, 1));
        d_wd = $urandom;
        d_be = 4'($urandom_range(1, 15));
        DataReqM = 1; MemWriteM = d_st; ALUResultM = d_addr;
        WriteDataM = d_wd; ByteEnM = d_be;
      end
    end
    check("rnd_drain", {f_act, d_act}, 0);
    check("rnd_buserr", BusErr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
